// File: rtl/core_pkg.sv
// Shared types and instruction-field helpers for the multicycle accumulator/register core.
// Instruction layout, MSB first: [opcode 4][rd RA_W][rs RA_W][imm ADDR_W].
package core_pkg;

    typedef enum logic [3:0] {
        OP_HALT  = 4'd0,
        OP_LOADI = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_LOAD  = 4'd4,
        OP_STORE = 4'd5,
        OP_JUMP  = 4'd6,
        OP_JEQZ  = 4'd7,
        OP_JNEZ  = 4'd8,
        OP_ADDI  = 4'd9,
        OP_NOP   = 4'd10
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    function automatic int unsigned instr_w(input int unsigned ra_w, input int unsigned addr_w);
        return 4 + 2 * ra_w + addr_w;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned ra_w, input int unsigned addr_w);
        return 2 * ra_w + addr_w;
    endfunction

    function automatic int unsigned rd_lsb(input int unsigned ra_w, input int unsigned addr_w);
        return ra_w + addr_w;
    endfunction

    function automatic int unsigned rs_lsb(input int unsigned ra_w, input int unsigned addr_w);
        return addr_w + 0 * ra_w;
    endfunction

endpackage

// File: rtl/core_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// R0 always reads as zero and ignores writes.
module core_regfile
    import core_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [$clog2(NREGS)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [$clog2(NREGS)-1:0]   raddr_a,
    input  logic [$clog2(NREGS)-1:0]   raddr_b,
    output logic [DATA_W-1:0]          rdata_a,
    output logic [DATA_W-1:0]          rdata_b
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle register core: FETCH -> DECODE -> EXEC -> {MEM -> WB | WB | FETCH | HALT},
// with instruction and data memories behind req/ack handshakes.
module multicycle_core
    import core_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned NREGS  = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    output logic                                 imem_req,
    output logic [ADDR_W-1:0]                    imem_addr,
    input  logic                                 imem_ack,
    input  logic [4+2*$clog2(NREGS)+ADDR_W-1:0]  imem_rdata,
    output logic                                 dmem_req,
    output logic                                 dmem_we,
    output logic [ADDR_W-1:0]                    dmem_addr,
    output logic [DATA_W-1:0]                    dmem_wdata,
    input  logic                                 dmem_ack,
    input  logic [DATA_W-1:0]                    dmem_rdata,
    output logic [ADDR_W-1:0]                    pc,
    output logic                                 halted,
    output logic                                 illegal
);

    localparam int unsigned RA_W    = $clog2(NREGS);
    localparam int unsigned INSTR_W = instr_w(RA_W, ADDR_W);
    localparam int unsigned OP_LSB  = op_lsb(RA_W, ADDR_W);
    localparam int unsigned RD_LSB  = rd_lsb(RA_W, ADDR_W);
    localparam int unsigned RS_LSB  = rs_lsb(RA_W, ADDR_W);

    state_e              state;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   wb_q;

    logic [3:0]          op;
    logic [RA_W-1:0]     rd;
    logic [RA_W-1:0]     rs;
    logic [ADDR_W-1:0]   imm;
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   rf_rd;
    logic [DATA_W-1:0]   rf_rs;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_sum;
    logic                alu_sub;

    assign op  = ir[OP_LSB +: 4];
    assign rd  = ir[RD_LSB +: RA_W];
    assign rs  = ir[RS_LSB +: RA_W];
    assign imm = ir[ADDR_W-1:0];

    // Sign-extends when DATA_W > ADDR_W, keeps the low DATA_W bits otherwise.
    assign imm_ext = DATA_W'($signed(imm));

    assign imem_addr = pc;

    core_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (state == S_WB),
        .waddr   (rd),
        .wdata   (wb_q),
        .raddr_a (rd),
        .raddr_b (rs),
        .rdata_a (rf_rd),
        .rdata_b (rf_rs)
    );

    // Single adder: subtraction as A + ~B + 1.
    always_comb begin
        alu_sub = (op == OP_SUB);
        alu_b   = (op == OP_ADDI) ? imm_ext : b_q;
        if (alu_sub) begin
            alu_b = ~alu_b;
        end
        alu_sum = a_q + alu_b + DATA_W'(alu_sub);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            a_q        <= '0;
            b_q        <= '0;
            wb_q       <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                S_FETCH: begin
                    // First cycle after reset arrives with req low; raise it here.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        pc       <= pc + ADDR_W'(1);
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    a_q   <= rf_rd;
                    b_q   <= rf_rs;
                    state <= S_EXEC;
                end

                S_EXEC: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                    case (op)
                        OP_HALT: begin
                            state    <= S_HALT;
                            imem_req <= 1'b0;
                            halted   <= 1'b1;
                        end
                        OP_LOADI: begin
                            wb_q     <= imm_ext;
                            state    <= S_WB;
                            imem_req <= 1'b0;
                        end
                        OP_ADD, OP_SUB, OP_ADDI: begin
                            wb_q     <= alu_sum;
                            state    <= S_WB;
                            imem_req <= 1'b0;
                        end
                        OP_LOAD, OP_STORE: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_STORE);
                            dmem_addr  <= ADDR_W'(b_q);
                            dmem_wdata <= a_q;
                            state      <= S_MEM;
                            imem_req   <= 1'b0;
                        end
                        OP_JUMP: begin
                            pc <= imm;
                        end
                        OP_JEQZ: begin
                            if (a_q == '0) begin
                                pc <= imm;
                            end
                        end
                        OP_JNEZ: begin
                            if (a_q != '0) begin
                                pc <= imm;
                            end
                        end
                        OP_NOP: begin
                        end
                        default: begin
                            illegal <= 1'b1;
                        end
                    endcase
                end

                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            wb_q  <= dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end

                S_WB: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
